// File: rtl/seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode 7-segment display.
// Each digit slot opens with a dark guard interval; leading zeros can be suppressed.
module seg_scan_ctrl #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 16,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_enable,
  input  logic [3:0] i_ones,
  input  logic [3:0] i_tens,
  input  logic [3:0] i_hundreds,
  input  logic [3:0] i_thousands,
  input  logic [3:0] i_dp_mask,
  output logic [3:0] o_an,
  output logic [6:0] o_seg,
  output logic       o_dp,
  output logic [1:0] o_scan_idx,
  output logic       o_frame_done
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BLANK = 2'd1,
    S_SHOW  = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]    r_idx, w_idx_nxt;
  logic [19:0]   r_snap, w_snap_nxt;
  logic [3:0]    r_an, w_an_nxt;
  logic [6:0]    r_seg, w_seg_nxt;
  logic          r_dp, w_dp_nxt;
  logic          r_fd, w_fd_nxt;
  logic [3:0]    w_digit;
  logic          w_lz;

  // Active-low segment pattern {g,f,e,d,c,b,a}; non-BCD codes render as a dash
  function automatic logic [6:0] f_seg_decode(input logic [3:0] i_bcd);
    logic [6:0] v;
    case (i_bcd)
      4'd0:    v = 7'b1000000;
      4'd1:    v = 7'b1111001;
      4'd2:    v = 7'b0100100;
      4'd3:    v = 7'b0110000;
      4'd4:    v = 7'b0011001;
      4'd5:    v = 7'b0010010;
      4'd6:    v = 7'b0000010;
      4'd7:    v = 7'b1111000;
      4'd8:    v = 7'b0000000;
      4'd9:    v = 7'b0010000;
      default: v = 7'b0111111;
    endcase
    return v;
  endfunction

  // Next-state, slot counter and frame snapshot
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_snap_nxt  = r_snap;
    w_fd_nxt    = 1'b0;
    if (!i_enable) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
      w_idx_nxt   = 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_BLANK;
          w_cnt_nxt   = '0;
          w_idx_nxt   = 2'd0;
          w_snap_nxt  = {i_thousands, i_hundreds, i_tens, i_ones, i_dp_mask};
        end
        S_BLANK: begin
          w_cnt_nxt = r_cnt + CW'(1);
          if (r_cnt == CW'(BLANK_CYCLES - 1)) begin
            w_state_nxt = S_SHOW;
          end else begin
            w_state_nxt = S_BLANK;
          end
        end
        S_SHOW: begin
          if (r_cnt == CW'(SCAN_DIV - 1)) begin
            w_cnt_nxt   = '0;
            w_idx_nxt   = r_idx + 2'd1;
            w_state_nxt = S_BLANK;
            // Frame boundary: announce it and sample the next frame's digits together
            if (r_idx == 2'd3) begin
              w_fd_nxt   = 1'b1;
              w_snap_nxt = {i_thousands, i_hundreds, i_tens, i_ones, i_dp_mask};
            end else begin
              w_fd_nxt   = 1'b0;
            end
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = 2'd0;
        end
      endcase
    end
  end

  // Digit selection and leading-zero detection for the upcoming slot
  always_comb begin
    w_digit = w_snap_nxt[7:4];
    w_lz    = 1'b0;
    case (w_idx_nxt)
      2'd0: begin
        w_digit = w_snap_nxt[7:4];
        w_lz    = 1'b0;
      end
      2'd1: begin
        w_digit = w_snap_nxt[11:8];
        w_lz    = (w_snap_nxt[19:8] == 12'd0);
      end
      2'd2: begin
        w_digit = w_snap_nxt[15:12];
        w_lz    = (w_snap_nxt[19:12] == 8'd0);
      end
      2'd3: begin
        w_digit = w_snap_nxt[19:16];
        w_lz    = (w_snap_nxt[19:16] == 4'd0);
      end
      default: begin
        w_digit = w_snap_nxt[7:4];
        w_lz    = 1'b0;
      end
    endcase
  end

  // Pin drive decoded from the next state so the outputs can be registered
  always_comb begin
    w_an_nxt  = 4'hF;
    w_seg_nxt = 7'h7F;
    w_dp_nxt  = 1'b1;
    if ((w_state_nxt == S_SHOW) && !((LZ_BLANK != 1'b0) && w_lz)) begin
      w_an_nxt  = ~(4'b0001 << w_idx_nxt);
      w_seg_nxt = f_seg_decode(w_digit);
      w_dp_nxt  = ~w_snap_nxt[w_idx_nxt];
    end else begin
      w_an_nxt  = 4'hF;
      w_seg_nxt = 7'h7F;
      w_dp_nxt  = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= 2'd0;
      r_snap  <= 20'd0;
      r_an    <= 4'hF;
      r_seg   <= 7'h7F;
      r_dp    <= 1'b1;
      r_fd    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_snap  <= w_snap_nxt;
      r_an    <= w_an_nxt;
      r_seg   <= w_seg_nxt;
      r_dp    <= w_dp_nxt;
      r_fd    <= w_fd_nxt;
    end
  end

  assign o_an         = r_an;
  assign o_seg        = r_seg;
  assign o_dp         = r_dp;
  assign o_scan_idx   = r_idx;
  assign o_frame_done = r_fd;

endmodule
